sd_spi_master: RTL
==================

// Module: sd_spi_master
// PURPOSE
//   Parametrised SD/SPI master for the AVR core's I/O window: byte transfer, 80-clock init,
//   multi-device chip select, run-time slow/fast clock, hardware wait-for-token with timeout.
//   Driven by a one-cycle sd_signal strobe from the port decoder; core polls sd_busy/sd_timeout.
// PARAMETERS
//   CS_COUNT      2    number of chip-select lines (>=1); CS_W = max(1,$clog2(CS_COUNT))
//   DIV_SLOW      31   SCLK half-period-1 in clocks for init/slow mode (25 MHz -> 390 kHz)
//   DIV_FAST      0    SCLK half-period-1 in clocks for fast mode (25 MHz -> 12.5 MHz)
//   TIMEOUT_BYTES 255  max 0xFF bytes clocked by WAIT before declaring timeout (1..65535)
// PORTS
//   clock       in   1        system clock
//   reset       in   1        synchronous, active-high
//   spi_cs      out  CS_COUNT chip selects, active-low
//   spi_sclk    out  1        SPI clock, mode 0 (idle low)
//   spi_miso    in   1        serial data from card
//   spi_mosi    out  1        serial data to card, MSB first
//   sd_signal   in   1        one-cycle command strobe
//   sd_cmd      in   3        0 XFER, 1 INIT, 2 SELECT, 3 DESELECT, 4 WAIT, 5 CRC
//   sd_out      in   8        byte to send (XFER)
//   sd_csel     in   CS_W     target device for SELECT
//   sd_fast     in   1        1 = DIV_FAST for XFER/WAIT/CRC, 0 = DIV_SLOW
//   sd_din      out  8        last byte received
//   sd_busy     out  1        command in progress
//   sd_timeout  out  1        last WAIT expired
//   sd_crc      out  7        running CRC7 of XFER bytes
// BEHAVIOUR
//   Reset: spi_cs all 1, spi_sclk 0, spi_mosi 1, sd_din FF, sd_busy 0, sd_timeout 0, sd_crc 0,
//     FSM IDLE; reset mid-byte aborts immediately, no partial sd_din update.
//   Accept: sd_signal seen in IDLE latches cmd/out/csel/fast, sd_busy=1 next cycle,
//     sd_timeout cleared. sd_signal while busy ignored (no queueing).
//   States: IDLE -> LOW -> HIGH -> (LOW | NEXT) -> DONE -> IDLE.
//   LOW: mosi = current bit, sclk=0, hold div+1 clocks. HIGH: sclk=1, sample miso on entry, hold
//     div+1. After 8 bits -> NEXT. Byte = 16*(div+1) clocks; busy high 16*(div+1)+1 cycles.
//   XFER: send sd_out, sd_din = received byte at busy fall.
//   INIT: all CS high, mosi 1, 80 SCLK periods (10 bytes FF) at DIV_SLOW regardless of sd_fast.
//   SELECT: spi_cs[sd_csel]=0, others 1; busy for 1 cycle; sd_csel>=CS_COUNT -> all CS high.
//   DESELECT: all CS high then one FF byte (8 clocks for card release) at chosen speed.
//   WAIT: send FF repeatedly; stop on first byte != FF (sd_din = it, timeout 0); after
//     TIMEOUT_BYTES bytes all FF: sd_din FF, sd_timeout 1. Byte counter 16-bit, no wrap.
//   SCLK returns low in DONE; mosi returns 1 in IDLE. Speed only changes between bytes.
//   CS state persists across commands except INIT/SELECT/DESELECT.
// CONFIGURATION
//   SD_CRC7_EN defined: CRC7 (poly x^7+x^3+1, MSB first) over each XFER byte sent; cleared by
//     SELECT and reset; CRC cmd sends {sd_crc,1'b1} as XFER and then clears sd_crc.
//   SD_CRC7_EN undefined: no CRC logic; sd_crc tied 7'h00; CRC cmd sends 8'hFF as XFER.
// TESTING
//   Reset then XFER 8'hA5 fast, miso=0 -> mosi 1,0,1,0,0,1,0,1; busy 17 cycles; sd_din 00.
//   INIT -> 80 sclk rises, each period 64 clocks, spi_cs all 1, mosi 1 throughout.
//   SELECT csel=1; XFER 40,00,00,00,00; CRC (EN) -> sd_crc 7'h4A before CRC, sixth byte 8'h95.
//   SELECT; XFER 48,00,00,01,AA; CRC (EN) -> sixth byte 8'h87; without macro -> 8'hFF, sd_crc 0.
//   WAIT, miso 1 except byte 3 = 8'h01 -> stops after 3 bytes, sd_din 01, timeout 0.
//   WAIT, miso stuck 1, TIMEOUT_BYTES=4 -> 4 bytes, sd_din FF, timeout 1; next XFER clears it.
//   sd_signal during busy ignored; reset asserted mid-XFER -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sd_spi_master_if.sv
// Command/status bus between the AVR I/O port decoder and sd_spi_master.
// master modport: core side (issues strobes, polls status).
// slave modport:  SPI master side.
interface sd_spi_master_if #(
    parameter int CS_COUNT = 2
);
    localparam int CS_W = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;

    logic            sd_signal;
    logic [2:0]      sd_cmd;
    logic [7:0]      sd_out;
    logic [CS_W-1:0] sd_csel;
    logic            sd_fast;
    logic [7:0]      sd_din;
    logic            sd_busy;
    logic            sd_timeout;
    logic [6:0]      sd_crc;

    modport master (
        output sd_signal, sd_cmd, sd_out, sd_csel, sd_fast,
        input  sd_din, sd_busy, sd_timeout, sd_crc
    );

    modport slave (
        input  sd_signal, sd_cmd, sd_out, sd_csel, sd_fast,
        output sd_din, sd_busy, sd_timeout, sd_crc
    );
endinterface

// File: rtl/sd_spi_master.sv
// SD/SPI master: byte transfer, 80-clock init, multi-device chip select,
// run-time slow/fast SCLK, hardware wait-for-token with timeout.
// Optional feature macro: SD_CRC7_EN (running CRC7 over XFER bytes and
// a CRC command that sends {crc,1}); when undefined sd_crc is tied to 0
// and the CRC command sends 8'hFF.
module sd_spi_master #(
    parameter int CS_COUNT      = 2,
    parameter int DIV_SLOW      = 31,
    parameter int DIV_FAST      = 0,
    parameter int TIMEOUT_BYTES = 255
) (
    input  logic                clock,
    input  logic                reset,
    output logic [CS_COUNT-1:0] spi_cs,
    output logic                spi_sclk,
    input  logic                spi_miso,
    output logic                spi_mosi,
    sd_spi_master_if.slave      bus
);

    localparam int CS_W    = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;
    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int DIV_W   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_S   = DIV_W'(DIV_SLOW);
    localparam logic [DIV_W-1:0] DIV_F   = DIV_W'(DIV_FAST);
    localparam logic [15:0]      TO_LAST = 16'(TIMEOUT_BYTES - 1);
    localparam logic [15:0]      INIT_LAST = 16'd9;

    typedef enum logic [2:0] {
        CMD_XFER     = 3'd0,
        CMD_INIT     = 3'd1,
        CMD_SELECT   = 3'd2,
        CMD_DESELECT = 3'd3,
        CMD_WAIT     = 3'd4,
        CMD_CRC      = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state, state_next;
    cmd_t             cmd_q;
    cmd_t             cmd_in;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [15:0]      byte_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       din_q;
    logic             tmo_q;
    logic [CS_COUNT-1:0] cs_q;

    logic             phase_end;
    logic             last_bit;
    logic             byte_last;
    logic             accept;
    logic             byte_end;
    logic [7:0]       tx_load;

`ifdef SD_CRC7_EN
    logic [6:0]       crc_q;

    // CRC7, polynomial x^7+x^3+1, data MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
        logic [6:0] r;
        logic [7:0] dd;
        logic       fb;
        r  = c;
        dd = d;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[6] ^ dd[7];
            r  = {r[5:0], 1'b0};
            dd = {dd[6:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction
`endif

    assign cmd_in    = cmd_t'(bus.sd_cmd);
    assign phase_end = (div_cnt == div_q);
    assign last_bit  = (bit_cnt == 3'd7);

    // First byte shifted out for the accepted command.
    always_comb begin
        tx_load = 8'hFF;
        case (cmd_in)
            CMD_XFER: tx_load = bus.sd_out;
`ifdef SD_CRC7_EN
            CMD_CRC:  tx_load = {crc_q, 1'b1};
`endif
            default:  tx_load = 8'hFF;
        endcase
    end

    // Decide whether the byte now finishing is the last one of the command.
    always_comb begin
        byte_last = 1'b1;
        case (cmd_q)
            CMD_INIT: byte_last = (byte_cnt == INIT_LAST);
            CMD_WAIT: byte_last = (rx_sr != 8'hFF) || (byte_cnt == TO_LAST);
            default:  byte_last = 1'b1;
        endcase
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        byte_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sd_signal) begin
                    accept = 1'b1;
                    case (cmd_in)
                        CMD_XFER, CMD_INIT, CMD_DESELECT, CMD_WAIT, CMD_CRC:
                            state_next = S_LOW;
                        default:
                            state_next = S_NEXT;
                    endcase
                end
            end
            S_LOW: begin
                if (phase_end) state_next = S_HIGH;
            end
            S_HIGH: begin
                if (phase_end) begin
                    if (last_bit) begin
                        byte_end   = 1'b1;
                        state_next = byte_last ? S_NEXT : S_LOW;
                    end else begin
                        state_next = S_LOW;
                    end
                end
            end
            S_NEXT:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Shift, divider, byte-count and status datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q    <= CMD_XFER;
            div_q    <= DIV_S;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sr    <= '1;
            rx_sr    <= '1;
            din_q    <= '1;
            tmo_q    <= 1'b0;
            cs_q     <= '1;
        end else begin
            if (state == S_LOW || state == S_HIGH)
                div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;

            if (accept) begin
                cmd_q    <= cmd_in;
                div_q    <= (cmd_in == CMD_INIT || !bus.sd_fast) ? DIV_S : DIV_F;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tmo_q    <= 1'b0;
                tx_sr    <= tx_load;
                case (cmd_in)
                    CMD_INIT, CMD_DESELECT: cs_q <= '1;
                    CMD_SELECT: begin
                        for (int unsigned i = 0; i < CS_COUNT; i++)
                            cs_q[i] <= (bus.sd_csel != CS_W'(i));
                    end
                    default: cs_q <= cs_q;
                endcase
            end

            // Sample MISO on the rising SCLK edge (entry to HIGH).
            if (state == S_LOW && phase_end)
                rx_sr <= {rx_sr[6:0], spi_miso};

            if (state == S_HIGH && phase_end) begin
                if (!last_bit) begin
                    tx_sr   <= {tx_sr[6:0], 1'b1};
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    bit_cnt <= '0;
                    din_q   <= rx_sr;
                    tx_sr   <= 8'hFF;
                    if (!byte_last)
                        byte_cnt <= byte_cnt + 16'd1;
                    if (cmd_q == CMD_WAIT && byte_last && rx_sr == 8'hFF)
                        tmo_q <= 1'b1;
                end
            end
        end
    end

`ifdef SD_CRC7_EN
    // Running CRC7: folded in at XFER accept, cleared by SELECT and after a CRC byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q <= '0;
        end else if (accept && cmd_in == CMD_XFER) begin
            crc_q <= crc7_byte(crc_q, bus.sd_out);
        end else if (accept && cmd_in == CMD_SELECT) begin
            crc_q <= '0;
        end else if (byte_end && cmd_q == CMD_CRC) begin
            crc_q <= '0;
        end
    end
    assign bus.sd_crc = crc_q;
`else
    assign bus.sd_crc = 7'h00;
`endif

    assign spi_cs         = cs_q;
    assign spi_sclk       = (state == S_HIGH);
    assign spi_mosi       = (state == S_LOW || state == S_HIGH) ? tx_sr[7] : 1'b1;
    assign bus.sd_busy    = (state == S_LOW || state == S_HIGH || state == S_NEXT);
    assign bus.sd_din     = din_q;
    assign bus.sd_timeout = tmo_q;

endmodule
